// File: rtl/game_flow_controller.sv
// Game flow controller: owns the live board state, stage sequencing, win detection
// and a circular multi-level undo history between the move engine and the level ROM.
module game_flow_controller #(
    parameter int CELLS      = 64,
    parameter int POS_W      = 6,
    parameter int UNDO_DEPTH = 8,
    parameter int STAGES     = 4,
    parameter int STAGE_W    = 2,
    parameter int WIN_HOLD   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [2*CELLS+POS_W-1:0]          init_state,
    input  logic [CELLS-1:0]                  destination,
    input  logic [2*CELLS+POS_W-1:0]          next_state,
    input  logic                              move_valid,
    input  logic                              retry,
    input  logic                              retract,
    output logic [2*CELLS+POS_W-1:0]          state_out,
    output logic                              state_en,
    output logic [1:0]                        sel,
    output logic [STAGE_W-1:0]                stage,
    output logic                              stage_up,
    output logic                              win,
    output logic [$clog2(UNDO_DEPTH+1)-1:0]   undo_count,
    output logic                              all_done
);

    localparam int SW     = 2*CELLS + POS_W;
    localparam int CNT_W  = $clog2(UNDO_DEPTH+1);
    localparam int PTR_W  = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
    localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

    typedef enum logic [1:0] {LOAD = 2'd0, PLAY = 2'd1, WIN = 2'd2, DONE = 2'd3} fsm_t;

    fsm_t                fsm_r, fsm_s;
    logic [SW-1:0]       state_r, state_s;
    logic [1:0]          sel_r, sel_s;
    logic [STAGE_W-1:0]  stage_r, stage_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [PTR_W-1:0]    ptr_r, ptr_s, ptr_inc_s, ptr_dec_s;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic                state_en_r, state_en_s;
    logic                stage_up_r, stage_up_s;
    logic                win_r, win_s;
    logic                all_done_r, all_done_s;
    logic                push_s;
    logic                win_cond_s;
    logic [CELLS-1:0]    box_s;
    logic [SW-1:0]       hist_r [UNDO_DEPTH];

    // Circular pointer neighbours and win detection on the registered board
    always_comb begin
        ptr_inc_s  = (ptr_r == PTR_W'(UNDO_DEPTH-1)) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);
        ptr_dec_s  = (ptr_r == {PTR_W{1'b0}}) ? PTR_W'(UNDO_DEPTH-1) : ptr_r - PTR_W'(1);
        box_s      = state_r[POS_W +: CELLS];
        win_cond_s = ((box_s & destination) == destination) && (destination != {CELLS{1'b0}});
    end

    // Next-state and next-output logic of the stage sequencer
    always_comb begin
        fsm_s      = fsm_r;
        state_s    = state_r;
        sel_s      = sel_r;
        stage_s    = stage_r;
        cnt_s      = cnt_r;
        ptr_s      = ptr_r;
        hold_s     = hold_r;
        win_s      = win_r;
        all_done_s = all_done_r;
        state_en_s = 1'b0;
        stage_up_s = 1'b0;
        push_s     = 1'b0;
        case (fsm_r)
            LOAD: begin
                state_s    = init_state;
                sel_s      = 2'd0;
                cnt_s      = {CNT_W{1'b0}};
                win_s      = 1'b0;
                state_en_s = 1'b1;
                fsm_s      = PLAY;
            end
            PLAY: begin
                // A solved board takes precedence over any player input
                if (win_cond_s) begin
                    fsm_s  = WIN;
                    win_s  = 1'b1;
                    hold_s = {HOLD_W{1'b0}};
                end else if (retry) begin
                    fsm_s = LOAD;
                end else if (retract) begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_s    = hist_r[ptr_dec_s];
                        ptr_s      = ptr_dec_s;
                        cnt_s      = cnt_r - CNT_W'(1);
                        sel_s      = 2'd2;
                        state_en_s = 1'b1;
                    end else begin
                        fsm_s = PLAY;
                    end
                end else if (move_valid) begin
                    push_s     = 1'b1;
                    state_s    = next_state;
                    ptr_s      = ptr_inc_s;
                    cnt_s      = (cnt_r == CNT_W'(UNDO_DEPTH)) ? cnt_r : cnt_r + CNT_W'(1);
                    sel_s      = 2'd1;
                    state_en_s = 1'b1;
                end else begin
                    fsm_s = PLAY;
                end
            end
            WIN: begin
                if (hold_r == HOLD_W'(WIN_HOLD-1)) begin
                    if (stage_r < STAGE_W'(STAGES-1)) begin
                        stage_up_s = 1'b1;
                        stage_s    = stage_r + STAGE_W'(1);
                        fsm_s      = LOAD;
                    end else begin
                        all_done_s = 1'b1;
                        fsm_s      = DONE;
                    end
                end else begin
                    hold_s = hold_r + HOLD_W'(1);
                end
            end
            DONE: begin
                if (retry) begin
                    stage_s    = {STAGE_W{1'b0}};
                    win_s      = 1'b0;
                    all_done_s = 1'b0;
                    fsm_s      = LOAD;
                end else begin
                    fsm_s = DONE;
                end
            end
            default: begin
                fsm_s = LOAD;
            end
        endcase
    end

    // Sequencer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r      <= LOAD;
            state_r    <= {SW{1'b0}};
            sel_r      <= 2'd0;
            stage_r    <= {STAGE_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ptr_r      <= {PTR_W{1'b0}};
            hold_r     <= {HOLD_W{1'b0}};
            state_en_r <= 1'b0;
            stage_up_r <= 1'b0;
            win_r      <= 1'b0;
            all_done_r <= 1'b0;
        end else begin
            fsm_r      <= fsm_s;
            state_r    <= state_s;
            sel_r      <= sel_s;
            stage_r    <= stage_s;
            cnt_r      <= cnt_s;
            ptr_r      <= ptr_s;
            hold_r     <= hold_s;
            state_en_r <= state_en_s;
            stage_up_r <= stage_up_s;
            win_r      <= win_s;
            all_done_r <= all_done_s;
        end
    end

    // Undo history: the board being replaced is written at the head slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UNDO_DEPTH; i++) begin
                hist_r[i] <= {SW{1'b0}};
            end
        end else if (push_s) begin
            hist_r[ptr_r] <= state_r;
        end
    end

    assign state_out  = state_r;
    assign state_en   = state_en_r;
    assign sel        = sel_r;
    assign stage      = stage_r;
    assign stage_up   = stage_up_r;
    assign win        = win_r;
    assign undo_count = cnt_r;
    assign all_done   = all_done_r;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Parametrised successor to the single-step game controller; owns the live board state, stage sequencing, win detection and a multi-level undo history.
- Sits between the move engine (which supplies legal candidate states) and the level ROM/display path.
- Generalised in board size, undo depth and stage count.
- Adds a circular retract history, a win hold interval and an all-stages-complete state.

Parameters:
- CELLS, 64, board cells; width of the way, box and destination bitmaps.
- POS_W, 6, man position width; CELLS <= 2^POS_W.
- UNDO_DEPTH, 8, retract history entries; >= 1.
- STAGES, 4, number of stages; >= 1.
- STAGE_W, 2, stage index width; STAGES <= 2^STAGE_W.
- WIN_HOLD, 4, cycles spent in WIN before stage_up; >= 1.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_state  in  2*CELLS+POS_W  {way, box, man}; level ROM output for current stage (combinational on stage).
- destination  in  CELLS  target-cell bitmap for current stage.
- next_state  in  2*CELLS+POS_W  candidate state from move engine.
- move_valid  in  1  one-cycle pulse: next_state is a legal move.
- retry  in  1  pulse: restart current stage.
- retract  in  1  pulse: undo one move.
- state_out  out  2*CELLS+POS_W  registered current state {way, box, man}.
- state_en  out  1  one-cycle pulse in the cycle after state_out changed.
- sel  out  2  source of last update: 0 = init, 1 = move, 2 = retract.
- stage  out  STAGE_W  current stage index.
- stage_up  out  1  one-cycle pulse on stage advance.
- win  out  1  level: current stage solved.
- undo_count  out  $clog2(UNDO_DEPTH+1)  valid history entries.
- all_done  out  1  level: final stage solved.

Behaviour:
- Reset (async assert, sync release): FSM = LOAD; state_out = 0; stage = 0; sel = 0; undo_count = 0; history pointer = 0; state_en, stage_up, win and all_done all 0.
- Reset mid-operation aborts everything, including a WIN hold.
- FSM states: LOAD, PLAY, WIN, DONE.
- LOAD (one cycle):
  - state_out <= init_state; sel <= 0; undo_count <= 0; win <= 0.
  - state_en is high the following cycle.
  - Next state: PLAY.
- PLAY input priority when simultaneous: retry > retract > move_valid. Lower-priority inputs in the same cycle are dropped.
  - retry: go to LOAD; stage unchanged.
  - retract with undo_count > 0: state_out <= newest history entry; pointer decrements modulo UNDO_DEPTH; undo_count - 1; sel <= 2; state_en pulse.
  - retract with undo_count == 0: ignored; no state_en.
  - move_valid: current state_out pushed to history; state_out <= next_state; sel <= 1; state_en pulse.
  - Push when the history is full overwrites the oldest entry; undo_count saturates at UNDO_DEPTH.
- Win condition is combinational on registered state_out: (box & destination) == destination, and destination != 0.
- If the win condition holds in PLAY at an edge:
  - FSM enters WIN and win = 1 at that edge.
  - So win is first high the cycle after state_en for the winning move.
  - A stage loaded already solved wins one cycle after LOAD.
- WIN:
  - retry, retract and move_valid are ignored.
  - A counter runs WIN_HOLD cycles.
  - On the final cycle, if stage < STAGES-1: stage_up pulses for one cycle, stage increments on the same edge, and the FSM goes to LOAD.
  - If stage == STAGES-1: the FSM goes to DONE with all_done = 1; win stays 1; no stage_up.
- DONE: holds. retry sets stage = 0, clears win and all_done, and goes to LOAD. Other inputs are ignored.
- Stage increment never wraps; STAGES == 1 goes straight to DONE.

Test Plan:
- Reset then release; init_state = {way = 0, box = 1, man = 0}, destination = 2 -> state_en pulses once, state_out = init_state, sel = 0, undo_count = 0, win = 0, stage = 0.
- 10 move_valid pulses with distinct next_state (man = 1..10), UNDO_DEPTH = 8 -> undo_count saturates at 8. Then 9 retract pulses -> man = 9,8,...,2; the 9th retract is ignored with no state_en; sel = 2.
- retry, retract and move_valid in the same cycle after 3 moves -> LOAD wins: state_out = init_state, undo_count = 0.
- move_valid with next_state box = 2, destination = 2 -> win = 1 one cycle after state_en. Then stage_up pulses exactly WIN_HOLD cycles later and stage goes 0 -> 1. Inputs during WIN produce no state_en.
- Win on stage 3 (STAGES = 4) -> all_done = 1, no stage_up, stage stays 3. Then retry -> stage = 0, all_done = 0, state_out = stage-0 init.
- Assert rst_n low during WIN hold -> outputs return to reset values immediately, with no stage_up.
